// File: rtl/note_detector.sv
// note_detector: measures the period of a square-wave tone and decodes it
// to a semitone index (octave*12 + semitone, index 0 = A2 at 110 Hz).
// Ports: CLK100MHZ clock; CPU_RESETN async active-low reset; tone_in async
//   square wave; note[5:0] decoded index; note_valid one-cycle update pulse;
//   tone_present in-range tone seen; range_err one-cycle out-of-range pulse;
//   busy decode FSM not idle.
// Option: define NOTE_DET_STABLE_EN to require two identical consecutive
//   decodes before note is updated.
module note_detector #(
  parameter int unsigned CLKSPEED     = 100000000,
  parameter int unsigned TIMEOUT_BITS = 21
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       tone_in,
  output logic [5:0] note,
  output logic       note_valid,
  output logic       tone_present,
  output logic       range_err,
  output logic       busy
);

  // Thresholds are given for a 100 MHz clock and scale with CLKSPEED.
  function automatic logic [23:0] scl(input longint unsigned c100);
    return 24'((c100 * 64'(CLKSPEED)) / 64'd100000000);
  endfunction

  localparam logic [23:0] B_HI = scl(64'd935729);
  localparam logic [23:0] B_LO = scl(64'd467865);
  localparam logic [23:0] T1   = scl(64'd883214);
  localparam logic [23:0] T2   = scl(64'd833640);
  localparam logic [23:0] T3   = scl(64'd786852);
  localparam logic [23:0] T4   = scl(64'd742690);
  localparam logic [23:0] T5   = scl(64'd701003);
  localparam logic [23:0] T6   = scl(64'd661660);
  localparam logic [23:0] T7   = scl(64'd624525);
  localparam logic [23:0] T8   = scl(64'd589474);
  localparam logic [23:0] T9   = scl(64'd556390);
  localparam logic [23:0] T10  = scl(64'd525163);
  localparam logic [23:0] T11  = scl(64'd495686);

  localparam logic [TIMEOUT_BITS-1:0] CNT_TOP = '1;
  localparam logic [TIMEOUT_BITS-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    CHECK,
    SEARCH,
    EMIT
  } state_t;

  state_t state, state_n;

  logic s0, s1, s2;
  logic rise;
  logic tmo;
  logic cap;
  logic armed;
  logic [TIMEOUT_BITS-1:0] cnt;

  logic [23:0] w, w_n;
  logic [2:0]  oct, oct_n;
  logic [3:0]  semi, semi_n;
  logic [3:0]  s, s_n;
  logic [5:0]  note_n;
  logic        nv_n, re_n, tp_n;
  logic [23:0] t_sel;
  logic [5:0]  dec;

`ifdef NOTE_DET_STABLE_EN
  logic [5:0] prev, prev_n;
  logic       pvld, pvld_n;
`endif

  assign rise = s1 & ~s2;
  // Fires once, on the cycle the counter steps into saturation.
  assign tmo  = ~rise & (cnt == (CNT_TOP - CNT_ONE));
  assign cap  = rise & armed & (state == IDLE);
  assign busy = (state != IDLE);
  assign dec  = 6'((7'(oct) * 7'd12) + 7'(semi));

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      s0 <= tone_in;
      s1 <= s0;
      s2 <= s1;
      if (rise) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else begin
        if (cnt != CNT_TOP) cnt <= cnt + CNT_ONE;
        if (tmo) armed <= 1'b0;
      end
    end
  end

  always_comb begin
    t_sel = '0;
    case (s)
      4'd1:    t_sel = T1;
      4'd2:    t_sel = T2;
      4'd3:    t_sel = T3;
      4'd4:    t_sel = T4;
      4'd5:    t_sel = T5;
      4'd6:    t_sel = T6;
      4'd7:    t_sel = T7;
      4'd8:    t_sel = T8;
      4'd9:    t_sel = T9;
      4'd10:   t_sel = T10;
      4'd11:   t_sel = T11;
      default: t_sel = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    w_n     = w;
    oct_n   = oct;
    semi_n  = semi;
    s_n     = s;
    note_n  = note;
    nv_n    = 1'b0;
    re_n    = 1'b0;
    tp_n    = tone_present;
`ifdef NOTE_DET_STABLE_EN
    prev_n  = prev;
    pvld_n  = pvld;
`endif
    unique case (state)
      IDLE: begin
        if (cap) begin
          w_n     = 24'(cnt) + 24'd1;
          oct_n   = '0;
          state_n = NORM;
        end
      end
      NORM: begin
        if (w < B_LO && oct < 3'd5) begin
          w_n   = w << 1;
          oct_n = oct + 3'd1;
        end else begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (w < B_LO || w > B_HI) begin
          re_n    = 1'b1;
          tp_n    = 1'b0;
          state_n = IDLE;
`ifdef NOTE_DET_STABLE_EN
          pvld_n  = 1'b0;
`endif
        end else begin
          semi_n  = '0;
          s_n     = 4'd1;
          state_n = SEARCH;
        end
      end
      SEARCH: begin
        // Thresholds descend, so the last one passed gives the semitone.
        if (w < t_sel) semi_n = s;
        if (s == 4'd11) state_n = EMIT;
        else s_n = s + 4'd1;
      end
      EMIT: begin
        state_n = IDLE;
`ifdef NOTE_DET_STABLE_EN
        prev_n = dec;
        pvld_n = 1'b1;
        if (pvld && prev == dec) begin
          note_n = dec;
          nv_n   = 1'b1;
          tp_n   = 1'b1;
        end
`else
        note_n = dec;
        nv_n   = 1'b1;
        tp_n   = 1'b1;
`endif
      end
      default: state_n = IDLE;
    endcase
    // Loss of tone overrides anything the FSM produced this cycle.
    if (tmo) begin
      note_n = '0;
      nv_n   = 1'b0;
      tp_n   = 1'b0;
`ifdef NOTE_DET_STABLE_EN
      pvld_n = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state        <= IDLE;
      w            <= '0;
      oct          <= '0;
      semi         <= '0;
      s            <= '0;
      note         <= '0;
      note_valid   <= 1'b0;
      range_err    <= 1'b0;
      tone_present <= 1'b0;
`ifdef NOTE_DET_STABLE_EN
      prev         <= '0;
      pvld         <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      w            <= w_n;
      oct          <= oct_n;
      semi         <= semi_n;
      s            <= s_n;
      note         <= note_n;
      note_valid   <= nv_n;
      range_err    <= re_n;
      tone_present <= tp_n;
`ifdef NOTE_DET_STABLE_EN
      prev         <= prev_n;
      pvld         <= pvld_n;
`endif
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: drives square waves of known period into note_detector
// and checks pulses, note and tone_present against a timestamp-based model.
module tb_note_detector;

  localparam int CLK = 100000;
  localparam int TB  = 11;
  localparam int MAX = (1 << TB) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tone;
  logic [5:0] note;
  logic       nv, tp, re, busy;

  note_detector #(
    .CLKSPEED(CLK),
    .TIMEOUT_BITS(TB)
  ) dut (
    .CLK100MHZ(clk),
    .CPU_RESETN(rst_n),
    .tone_in(tone),
    .note(note),
    .note_valid(nv),
    .tone_present(tp),
    .range_err(re),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected events keyed by cycle: 1 note, 2 range error,
  // 3 timeout, 4 last cycle before timeout.
  int         ev_kind [int];
  logic [5:0] ev_note [int];
  bit         ev_tp   [int];

  int   thr [11];
  int   lo, hi;
  bit   m_armed;
  int   m_last;
  logic [5:0] m_note;
  bit   m_tp;
`ifdef NOTE_DET_STABLE_EN
  logic [5:0] m_prev;
  bit   m_pvld;
`endif

  function automatic int scl(input int x);
    return int'((longint'(x) * longint'(CLK)) / 64'd100000000);
  endfunction

  task automatic sched(input int c, input int k, input logic [5:0] n,
                       input bit t);
    ev_kind[c] = k;
    ev_note[c] = n;
    ev_tp[c]   = t;
  endtask

  task automatic model_reset();
    ev_kind.delete();
    ev_note.delete();
    ev_tp.delete();
    m_armed = 0;
    m_note  = '0;
    m_tp    = 0;
`ifdef NOTE_DET_STABLE_EN
    m_pvld  = 0;
`endif
  endtask

  // Input edge at cycle c; decode the interval since the previous edge.
  task automatic model_edge(input int c);
    longint w;
    int     iv, oct, semi;
    bit     ok;
    logic [5:0] nt;
    if (m_armed) begin
      iv  = c - m_last;
      w   = iv;
      oct = 0;
      while (w < lo && oct < 5) begin
        w = w * 2;
        oct++;
      end
      ok   = (w >= lo) && (w <= hi);
      semi = 0;
      for (int i = 0; i < 11; i++) if (w < thr[i]) semi++;
      nt = 6'(oct * 12 + semi);
      if (!ok) begin
        sched(c + 5 + oct, 2, m_note, 0);
        m_tp = 0;
`ifdef NOTE_DET_STABLE_EN
        m_pvld = 0;
`endif
      end else begin
`ifdef NOTE_DET_STABLE_EN
        if (m_pvld && m_prev == nt) begin
          sched(c + 17 + oct, 1, nt, 1);
          m_note = nt;
          m_tp   = 1;
        end
        m_prev = nt;
        m_pvld = 1;
`else
        sched(c + 17 + oct, 1, nt, 1);
        m_note = nt;
        m_tp   = 1;
`endif
      end
    end
    m_armed = 1;
    m_last  = c;
  endtask

  task automatic model_quiet();
    if (m_armed) begin
      sched(m_last + 2 + MAX, 4, m_note, m_tp);
      sched(m_last + 3 + MAX, 3, 6'd0, 0);
      m_note  = '0;
      m_tp    = 0;
      m_armed = 0;
`ifdef NOTE_DET_STABLE_EN
      m_pvld  = 0;
`endif
    end
  endtask

  // One period: rising edge now, falling edge half way, returns at next
  // rising-edge slot. Entered and left #1 after a posedge.
  task automatic tone_cycle(input int p);
    tone = 1'b1;
    model_edge(cyc);
    repeat (p / 2) @(posedge clk);
    #1 tone = 1'b0;
    repeat (p - p / 2) @(posedge clk);
    #1;
  endtask

  int mk;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ev_kind.exists(cyc)) begin
        mk = ev_kind[cyc];
        case (mk)
          1: begin
            check("note_valid", 32'(nv), 1);
            check("note", 32'(note), 32'(ev_note[cyc]));
            check("tp_set", 32'(tp), 1);
            check("re_quiet", 32'(re), 0);
          end
          2: begin
            check("range_err", 32'(re), 1);
            check("note_hold", 32'(note), 32'(ev_note[cyc]));
            check("tp_clr_rerr", 32'(tp), 0);
            check("nv_quiet", 32'(nv), 0);
          end
          3: begin
            check("tmo_note", 32'(note), 0);
            check("tmo_tp", 32'(tp), 0);
            check("tmo_nv", 32'(nv), 0);
          end
          default: begin
            check("pre_tmo_note", 32'(note), 32'(ev_note[cyc]));
            check("pre_tmo_tp", 32'(tp), 32'(ev_tp[cyc]));
          end
        endcase
        ev_kind.delete(cyc);
        ev_note.delete(cyc);
        ev_tp.delete(cyc);
      end else if (nv || re) begin
        check("spurious_pulse", {30'd0, nv, re}, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int base [11] = '{883214, 833640, 786852, 742690, 701003, 661660,
                    624525, 589474, 556390, 525163, 495686};
  int bnd [8] = '{467, 466, 935, 936, 883, 882, 30, 1000};

  initial begin
    for (int i = 0; i < 11; i++) thr[i] = scl(base[i]);
    lo = scl(467865);
    hi = scl(935729);
    model_reset();
    rst_n = 1'b0;
    tone  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_note", 32'(note), 0);
    check("rst_nv", 32'(nv), 0);
    check("rst_tp", 32'(tp), 0);
    check("rst_re", 32'(re), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (3) tone_cycle(227);
    repeat (3) tone_cycle(382);
    repeat (2) tone_cycle(1111);
    repeat (4) tone_cycle(10);
    foreach (bnd[i]) tone_cycle(bnd[i]);
    repeat (40) tone_cycle(int'($urandom_range(1000, 30)));
    repeat (2) tone_cycle(227);

    // Abort a decode in SEARCH with reset.
    tone = 1'b1;
    model_edge(cyc);
    repeat (9) @(posedge clk);
    #2;
    check("busy_in_search", 32'(busy), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_note", 32'(note), 0);
    check("mid_rst_nv", 32'(nv), 0);
    check("mid_rst_tp", 32'(tp), 0);
    check("mid_rst_re", 32'(re), 0);
    check("mid_rst_busy", 32'(busy), 0);
    tone = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tone_cycle(227);

    // Input goes quiet: note and tone_present drop on saturation.
    model_quiet();
    repeat (MAX + 40) @(posedge clk);
    #1;
    repeat (2) tone_cycle(227);
    repeat (40) @(posedge clk);
    #1;
    check("events_drained", 32'(ev_kind.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/note_detector.md
NOTE_DETECTOR -- requirements
Module: note_detector

Interface
REQ-001 The block SHALL have these parameters: CLKSPEED, default 100000000, clock frequency in Hz (the threshold constants in REQ-013 are defined for this value); TIMEOUT_BITS, default 21, width of the period counter.
REQ-002 CLK100MHZ  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 CPU_RESETN  input  1  reset; asynchronous assert, active-low.
REQ-004 tone_in  input  1  asynchronous square wave (PMOD audio tap or comparator output); one rising edge per period.
REQ-005 note  output  6  decoded note index: octave*12 + semitone, with semitone 0 = A; index 0 = A2 (110 Hz).
REQ-006 note_valid  output  1  one-cycle pulse when note is updated.
REQ-007 tone_present  output  1  high while in-range edges are arriving.
REQ-008 range_err  output  1  one-cycle pulse when a measured period is outside the decodable range.
REQ-009 busy  output  1  high while the decode FSM is not in IDLE.

Function
REQ-010 tone_in SHALL pass through a 2-FF synchronizer; a rising edge is sync_q1 & ~sync_q2, which is 3 cycles after the input edge.
REQ-011 The period counter (TIMEOUT_BITS wide) SHALL clear on each rising edge, increment otherwise, and saturate at all-ones.
REQ-012 Arming: the first rising edge after reset or after a timeout SHALL only clear the counter; each later edge SHALL capture counter+1 as P and start decode if the FSM is in IDLE; an edge arriving while busy SHALL be discarded, with no output change.
REQ-013 Constants (clocks): B_HI=935729, B_LO=467865; T1..T11 = 883214, 833640, 786852, 742690, 701003, 661660, 624525, 589474, 556390, 525163, 495686.
REQ-014 FSM states: IDLE, NORM, CHECK, SEARCH, EMIT.
  - IDLE->NORM on a captured period.
  - NORM: while W<B_LO and oct<5, W<=W<<1 and oct++, one step per cycle; otherwise ->CHECK.
  - CHECK: if W<B_LO or W>B_HI, pulse range_err and go ->IDLE; else semi=0, s=1, ->SEARCH.
  - SEARCH: one compare per cycle; if W<Ts then semi=s; after s=11, ->EMIT.
  - EMIT: note<=oct*12+semi, pulse note_valid, ->IDLE.
REQ-015 The working register W SHALL be 24 bits wide so that 5 left shifts cannot overflow.
REQ-016 Latency from the capturing edge to note_valid SHALL be 1+n+1+11+1 cycles, where n is the number of shifts (0..5); the maximum is 19 cycles.
REQ-017 tone_present SHALL set on each note_valid, and SHALL clear when the counter saturates or on range_err.
REQ-018 Timeout: when the counter saturates, the block SHALL set note<=0, clear tone_present, and disarm; it SHALL NOT pulse note_valid.
REQ-019 On range_err, note SHALL hold its previous value.
REQ-020 If a timeout and EMIT occur in the same cycle, the timeout SHALL win: note=0, tone_present=0, and no note_valid pulse.

Reset
REQ-021 Asserting CPU_RESETN low SHALL immediately force: note=0, note_valid=0, tone_present=0, range_err=0, busy=0, FSM=IDLE, synchronizer=0, counter=0, disarmed.
REQ-022 Reset asserted mid-decode SHALL abort the decode with no pulse; after release, the block SHALL need two rising edges before any decode.

Configuration
REQ-023 With NOTE_DET_STABLE_EN defined, EMIT SHALL update note and pulse note_valid only when the decoded value equals the previous decode result, so two consecutive identical decodes are required; the previous-decode register SHALL be cleared by reset, timeout, and range_err.
REQ-024 Without NOTE_DET_STABLE_EN, every EMIT SHALL update note and pulse note_valid.

Verification
REQ-025 A 440 Hz input (period 227273) SHALL make the NORM state shift twice, and the block SHALL then output note=24 with note_valid 19 cycles after the second edge, and tone_present=1.
REQ-026 A 261.63 Hz input (period 382219) SHALL give note=15 (octave 1, semitone 3); with NOTE_DET_STABLE_EN, the first pulse SHALL occur on the third edge.
REQ-027 A 90 Hz input (period 1111111) SHALL pulse range_err, hold note, and clear tone_present.
REQ-028 A 10 kHz input (period 10000) SHALL still be below B_LO after 5 shifts, so the block SHALL pulse range_err.
REQ-029 A 440 Hz input followed by input held low SHALL, 2^21-1 cycles after the last edge, give note=0 and tone_present=0 with no note_valid pulse.
REQ-030 Asserting CPU_RESETN during SEARCH SHALL immediately return all outputs to 0; after release, a 440 Hz input SHALL produce no note_valid before its second edge.
